// File: rtl/pwm_update_scheduler_if.sv
// Configuration strobe and output pin bundle between the register file and the PWM scheduler.
// The master drives configuration; the slave (scheduler) drives pins and status.
interface pwm_update_scheduler_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic        cfg_valid;
    logic [15:0] out;
    logic        period_start;
    logic        update_pending;
    logic        update_applied;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle, cfg_valid,
        input  out, period_start, update_pending, update_applied
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle, cfg_valid,
        output out, period_start, update_pending, update_applied
    );
endinterface

// File: rtl/pwm_update_scheduler.sv
// PWM period counter with shadowed configuration committed only at period boundaries.
// Optional duty ramping is enabled by defining DUTY_RAMP_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | active config up to date, shadow holds nothing new
// ST_PENDING | shadow holds a config waiting for the next period boundary
// ST_RAMPING | enables committed, duty stepping toward target (DUTY_RAMP_EN)
module pwm_update_scheduler #(
    parameter int unsigned PRESCALE  = 4,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pwm_update_scheduler_if.slave  bus
);

    if (PRESCALE < 1 || PRESCALE > 65535 || RAMP_STEP < 1) begin : g_bad_param
        $error("pwm_update_scheduler: PRESCALE must be 1..65535 and RAMP_STEP >= 1");
    end

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1
`ifdef DUTY_RAMP_EN
        ,
        ST_RAMPING = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        period_start_q;
    logic        pending_q;
    logic        applied_q, applied_d;
    logic [15:0] sh_en_out_q, sh_en_out_d;
    logic [15:0] sh_en_pwm_q, sh_en_pwm_d;
    logic [7:0]  sh_duty_q, sh_duty_d;
    logic [15:0] act_en_out_q, act_en_out_d;
    logic [15:0] act_en_pwm_q, act_en_pwm_d;
    logic [7:0]  act_duty_q, act_duty_d;
    logic [15:0] out_q, out_d;

    logic        tick;
    logic        boundary;
    logic        level;
    logic [15:0] in_en_out, in_en_pwm;
    logic [15:0] src_en_out, src_en_pwm;
    logic [7:0]  src_duty;

`ifdef DUTY_RAMP_EN
    localparam int unsigned STEP_C = (RAMP_STEP > 255) ? 255 : RAMP_STEP;
    localparam logic [7:0]  STEP8  = 8'(STEP_C);

    logic [7:0] tgt_duty_q, tgt_duty_d;
    logic [7:0] ramp_next;

    // Moves cur toward tgt by at most STEP8, landing exactly on tgt when closer.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > STEP8) ? cur + STEP8 : tgt;
        end else begin
            diff = cur - tgt;
            return (diff > STEP8) ? cur - STEP8 : tgt;
        end
    endfunction
`endif

    assign in_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign in_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // A strobe on the boundary cycle bypasses the shadow so the newest inputs win.
    assign src_en_out = bus.cfg_valid ? in_en_out          : sh_en_out_q;
    assign src_en_pwm = bus.cfg_valid ? in_en_pwm          : sh_en_pwm_q;
    assign src_duty   = bus.cfg_valid ? bus.pwm_duty_cycle : sh_duty_q;

    assign tick     = (pre_cnt_q == PRE_LAST);
    assign boundary = tick && (pwm_cnt_q == 8'hFF);
    assign level    = (act_duty_q == 8'hFF) || (pwm_cnt_q < act_duty_q);

    assign pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    assign pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    assign out_d     = act_en_out_q & (~act_en_pwm_q | {16{level}});

    assign sh_en_out_d = bus.cfg_valid ? in_en_out          : sh_en_out_q;
    assign sh_en_pwm_d = bus.cfg_valid ? in_en_pwm          : sh_en_pwm_q;
    assign sh_duty_d   = bus.cfg_valid ? bus.pwm_duty_cycle : sh_duty_q;

`ifdef DUTY_RAMP_EN
    assign ramp_next = ramp_step(act_duty_q, src_duty);
`endif

    always_comb begin
        state_d      = state_q;
        applied_d    = 1'b0;
        act_en_out_d = act_en_out_q;
        act_en_pwm_d = act_en_pwm_q;
        act_duty_d   = act_duty_q;
`ifdef DUTY_RAMP_EN
        tgt_duty_d   = tgt_duty_q;
`endif
        case (state_q)
            ST_IDLE, ST_PENDING: begin
                if (boundary && (bus.cfg_valid || state_q == ST_PENDING)) begin
                    act_en_out_d = src_en_out;
                    act_en_pwm_d = src_en_pwm;
`ifdef DUTY_RAMP_EN
                    tgt_duty_d = src_duty;
                    if (src_duty == act_duty_q) begin
                        applied_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RAMPING;
                    end
`else
                    act_duty_d = src_duty;
                    applied_d  = 1'b1;
                    state_d    = ST_IDLE;
`endif
                end else if (bus.cfg_valid) begin
                    state_d = ST_PENDING;
                end
            end
`ifdef DUTY_RAMP_EN
            ST_RAMPING: begin
                if (bus.cfg_valid) tgt_duty_d = bus.pwm_duty_cycle;
                if (boundary) begin
                    act_en_out_d = src_en_out;
                    act_en_pwm_d = src_en_pwm;
                    act_duty_d   = ramp_next;
                    tgt_duty_d   = src_duty;
                    if (ramp_next == src_duty) begin
                        applied_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
            pending_q      <= 1'b0;
            applied_q      <= 1'b0;
            sh_en_out_q    <= '0;
            sh_en_pwm_q    <= '0;
            sh_duty_q      <= '0;
            act_en_out_q   <= '0;
            act_en_pwm_q   <= '0;
            act_duty_q     <= '0;
            out_q          <= '0;
`ifdef DUTY_RAMP_EN
            tgt_duty_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= boundary;
            pending_q      <= (state_d != ST_IDLE);
            applied_q      <= applied_d;
            sh_en_out_q    <= sh_en_out_d;
            sh_en_pwm_q    <= sh_en_pwm_d;
            sh_duty_q      <= sh_duty_d;
            act_en_out_q   <= act_en_out_d;
            act_en_pwm_q   <= act_en_pwm_d;
            act_duty_q     <= act_duty_d;
            out_q          <= out_d;
`ifdef DUTY_RAMP_EN
            tgt_duty_q     <= tgt_duty_d;
`endif
        end
    end

    assign bus.out            = out_q;
    assign bus.period_start   = period_start_q;
    assign bus.update_pending = pending_q;
    assign bus.update_applied = applied_q;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Scoreboard bench: per-period expectations (high counts on out[0]/out[15], commit pulses)
// are queued when configuration is driven and checked as each PWM period closes.
module tb_pwm_update_scheduler;

    localparam int PRE    = 4;
    localparam int PERIOD = 256 * PRE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_update_scheduler_if bus_if();

    pwm_update_scheduler #(.PRESCALE(PRE), .RAMP_STEP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int win;
        int len;
        int o0;
        int o15;
        int app;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;

    int n_checks = 0;
    int n_errors = 0;
    int win_idx  = 0;
    int samp     = 0;
    int ones0    = 0;
    int ones15   = 0;
    int napp     = 0;
    int cur0     = 0;
    int cur15    = 0;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // One window = the 1024 output samples of one PWM period, closed on period_start.
    always @(negedge clk) begin
        samp++;
        if (bus_if.out[0] === 1'b1) ones0++;
        if (bus_if.out[15] === 1'b1) ones15++;
        if (bus_if.update_applied === 1'b1) napp++;
        if (bus_if.period_start === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].win == win_idx) begin
                e_m = exp_q.pop_front();
                if (e_m.len != 0) check($sformatf("win%0d_len", win_idx), samp, e_m.len);
                check($sformatf("win%0d_out0_high", win_idx), ones0, e_m.o0);
                check($sformatf("win%0d_out15_high", win_idx), ones15, e_m.o15);
                check($sformatf("win%0d_applied", win_idx), napp, e_m.app);
            end
            win_idx++;
            samp   = 0;
            ones0  = 0;
            ones15 = 0;
            napp   = 0;
        end
    end

    task automatic wait_ps(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 3 * PERIOD) begin
            @(negedge clk);
            cycles++;
            if (bus_if.period_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL period_start_timeout: got none within %0d cycles", cycles);
            $fatal(1, "period_start never seen");
        end
        #1;
    endtask

    task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d,
                         input bit expect_pend);
        bus_if.en_reg_out_7_0  = eo[7:0];
        bus_if.en_reg_out_15_8 = eo[15:8];
        bus_if.en_reg_pwm_7_0  = ep[7:0];
        bus_if.en_reg_pwm_15_8 = ep[15:8];
        bus_if.pwm_duty_cycle  = d;
        bus_if.cfg_valid       = 1'b1;
        @(negedge clk);
        bus_if.cfg_valid = 1'b0;
        if (expect_pend) check("pending_after_cfg", bus_if.update_pending, 1);
    endtask

    // Drive a config mid-period: this period keeps the old output and sees one commit.
    task automatic step_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d,
                            input int new0, input int new15);
        int c;
        repeat (300) @(negedge clk);
        exp_q.push_back('{win: win_idx, len: PERIOD, o0: cur0, o15: cur15, app: 1});
        drive(eo, ep, d, 1'b1);
        cur0  = new0;
        cur15 = new15;
        wait_ps(c);
        check("pending_cleared_at_boundary", bus_if.update_pending, 0);
    endtask

    initial begin
        bus_if.en_reg_out_7_0  = '0;
        bus_if.en_reg_out_15_8 = '0;
        bus_if.en_reg_pwm_7_0  = '0;
        bus_if.en_reg_pwm_15_8 = '0;
        bus_if.pwm_duty_cycle  = '0;
        bus_if.cfg_valid       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", bus_if.out, 0);
        check("reset_pending", bus_if.update_pending, 0);
        check("reset_applied", bus_if.update_applied, 0);
        check("reset_period_start", bus_if.period_start, 0);
        rst_n = 1'b1;
        wait_ps(cyc);
        check("first_period_len", cyc, PERIOD);

        // Reset in the middle of a pending update discards it.
        repeat (300) @(negedge clk);
        drive(16'h0001, 16'h0001, 8'd128, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_out", bus_if.out, 0);
        check("midreset_pending", bus_if.update_pending, 0);
        exp_q.push_back('{win: win_idx,     len: 0,      o0: 0, o15: 0, app: 0});
        exp_q.push_back('{win: win_idx + 1, len: PERIOD, o0: 0, o15: 0, app: 0});
        rst_n = 1'b1;
        wait_ps(cyc);
        check("post_reset_period_len", cyc, PERIOD);
        wait_ps(cyc);

        step_cfg(16'h0001, 16'h0001, 8'd128, 512, 0);
        step_cfg(16'h0001, 16'h0001, 8'd0, 0, 0);
        step_cfg(16'h0001, 16'h0001, 8'd255, PERIOD, 0);
        step_cfg(16'h8000, 16'h0000, 8'd255, 0, PERIOD);

        // Two strobes in one period: latest (duty 200) wins, single commit.
        repeat (200) @(negedge clk);
        exp_q.push_back('{win: win_idx, len: PERIOD, o0: cur0, o15: cur15, app: 1});
        drive(16'h0001, 16'h0001, 8'd64, 1'b1);
        repeat (400) @(negedge clk);
        drive(16'h0001, 16'h0001, 8'd200, 1'b1);
        cur0  = 200 * PRE;
        cur15 = 0;
        wait_ps(cyc);

        // Strobe exactly on the boundary cycle commits directly, never pending.
        exp_q.push_back('{win: win_idx, len: PERIOD, o0: cur0, o15: cur15, app: 1});
        repeat (PERIOD - 1) @(negedge clk);
        bus_if.en_reg_out_7_0  = 8'h01;
        bus_if.en_reg_out_15_8 = 8'h00;
        bus_if.en_reg_pwm_7_0  = 8'h01;
        bus_if.en_reg_pwm_15_8 = 8'h00;
        bus_if.pwm_duty_cycle  = 8'd32;
        bus_if.cfg_valid       = 1'b1;
        @(negedge clk);
        bus_if.cfg_valid = 1'b0;
        check("bypass_period_start", bus_if.period_start, 1);
        check("bypass_pending", bus_if.update_pending, 0);
        cur0  = 32 * PRE;
        cur15 = 0;
        repeat (300) @(negedge clk);
        check("bypass_pending_mid", bus_if.update_pending, 0);
        exp_q.push_back('{win: win_idx, len: PERIOD, o0: cur0, o15: cur15, app: 0});
        wait_ps(cyc);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
